rx_serial_param: RTL and testbench

Parametrised asynchronous serial receiver: the next generation of the team's fixed-format receivers. Data width, parity mode, stop-bit count and baud divisor are set at elaboration. It detects and validates the start bit, samples each bit at mid-bit, checks parity and stop bits, and presents the received word with a one-cycle completion pulse and error flags. It sits between the RX pin (GPIO) and the application logic or display decoders.

---
 rtl/rx_serial_pkg.sv | 26 ++
 rtl/rx_baud_counter.sv | 55 +++++
 rtl/rx_serial_param.sv | 270 +++++++++++++++++++++++++++
 tb/tb_rx_serial_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_serial_pkg.sv
// -----------------------------------------------------------------------------
// rx_serial_pkg
// Shared definitions for the parametrised serial receiver (rx_serial_param)
// and its baud counter (rx_baud_counter).
//   state_t   : 4-bit FSM encoding, also driven out on db_estado
//   PAR_*     : parity mode selectors for the PARITY parameter
// -----------------------------------------------------------------------------
package rx_serial_pkg;

  // FSM state encoding. The numeric values are visible on db_estado,
  // so they are fixed explicitly rather than left to the enum default.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4,
    ST_DONE   = 4'd5
  } state_t;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/rx_baud_counter.sv
// -----------------------------------------------------------------------------
// rx_baud_counter
// Bit-timing counter for the serial receiver. Counts clock cycles and raises
// tick for one cycle when the count reaches its target, then wraps to 0 so
// consecutive bits in the same state are spaced CLK_DIV cycles apart.
//
// Parameters:
//   CLK_DIV   clock cycles per serial bit (4..65535)
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-high; clears the count
//   zera      in   clear the count (asserted by the FSM on every state entry)
//   meio_sel  in   1: half-bit target CLK_DIV/2-1 (start bit centring)
//                  0: full-bit target CLK_DIV-1
//   tick      out  count equals the selected target (combinational)
// -----------------------------------------------------------------------------
module rx_baud_counter #(
  parameter int CLK_DIV = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic meio_sel,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [W-1:0] FULL_TGT = W'(CLK_DIV - 1);
  localparam logic [W-1:0] HALF_TGT = W'(CLK_DIV / 2 - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] target;

  always_comb begin
    target = meio_sel ? HALF_TGT : FULL_TGT;
    tick   = (cnt_q == target);
    cnt_d  = cnt_q + W'(1);
    // Wrapping on tick keeps the bit grid aligned while the FSM stays in
    // the same state (DATA, STOP with two stop bits).
    if (zera || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_serial_param.sv
// -----------------------------------------------------------------------------
// rx_serial_param
// Parametrised asynchronous serial receiver. Detects the start bit, centres
// sampling on each bit, receives DATA_BITS data bits LSB first, optionally
// checks parity, checks STOP_BITS stop bits and reports the word with a
// one-cycle completion pulse plus error flags.
//
// Parameters:
//   CLK_DIV    clock cycles per bit (4..65535)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 none, 1 even, 2 odd
//   STOP_BITS  1 or 2
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   RX             in   serial line, idle high
//   dados          out  last received word, held until the next frame ends
//   pronto         out  one-cycle completion pulse (also for errored frames)
//   erro_paridade  out  parity error of last frame (always 0 when PARITY=0)
//   erro_stop      out  framing error of last frame (a stop bit sampled low)
//   ocupado        out  FSM not in IDLE
//   db_estado      out  current FSM state encoding
//
// Output protocol: pronto is a pure notification pulse with no backpressure.
// dados, erro_paridade and erro_stop change on the same edge that raises
// pronto and are stable for the whole pulse and afterwards, so a consumer
// may capture them on any edge where pronto is high.
//
// Build option:
//   RX_SYNC_EN  defined: RX goes through a 2-flop synchronizer (flops reset
//               to 1); all sampling and pronto move 2 cycles later.
//               undefined: RX is used as-is and must already be synchronous.
// -----------------------------------------------------------------------------
module rx_serial_param
  import rx_serial_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 7,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] dados,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_stop,
  output logic                 ocupado,
  output logic [3:0]           db_estado
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  // ---------------------------------------------------------------------------
  // Line input
  // ---------------------------------------------------------------------------
  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], RX};
  end

  // Reset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = RX;
`endif

  // ---------------------------------------------------------------------------
  // Baud counter
  // ---------------------------------------------------------------------------
  logic tick;
  logic zera;
  logic meio_sel;

  rx_baud_counter #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clock    (clock),
    .reset    (reset),
    .zera     (zera),
    .meio_sel (meio_sel),
    .tick     (tick)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] sh_q;
  logic [DATA_BITS-1:0] sh_d;
  logic [3:0]           bit_cnt_q;
  logic [3:0]           bit_cnt_d;
  logic                 par_err_q;
  logic                 par_err_d;
  logic                 stop_err_q;
  logic                 stop_err_d;
  logic [DATA_BITS-1:0] dados_q;
  logic [DATA_BITS-1:0] dados_d;
  logic                 erro_par_q;
  logic                 erro_par_d;
  logic                 erro_stop_q;
  logic                 erro_stop_d;

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Mid start bit: a high line means the low pulse was a glitch.
        if (tick) begin
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && (bit_cnt_q == LAST_DATA)) begin
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && (bit_cnt_q == LAST_STOP)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and baud counter control
  // ---------------------------------------------------------------------------
  always_comb begin
    ocupado   = (state_q != ST_IDLE);
    pronto    = (state_q == ST_DONE);
    db_estado = state_q;
    // Any state change restarts bit timing from zero.
    zera      = (state_d != state_q);
    meio_sel  = (state_q == ST_START);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    par_err_d   = par_err_q;
    stop_err_d  = stop_err_q;
    dados_d     = dados_q;
    erro_par_d  = erro_par_q;
    erro_stop_d = erro_stop_q;

    unique case (state_q)
      ST_DATA: begin
        if (tick) begin
          // LSB arrives first, so shifting in at the MSB leaves the word
          // correctly aligned after DATA_BITS samples.
          sh_d      = {rx_s, sh_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (PARITY == PAR_ODD) begin
            par_err_d = ~(^sh_q ^ rx_s);
          end else begin
            par_err_d = ^sh_q ^ rx_s;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!rx_s) begin
            stop_err_d = 1'b1;
          end
          // Publish on the edge that enters DONE so the word and flags are
          // already valid while pronto is high. The last stop sample is
          // folded in directly since stop_err_q has not seen it yet.
          if (bit_cnt_q == LAST_STOP) begin
            dados_d     = sh_q;
            erro_par_d  = par_err_q;
            erro_stop_d = stop_err_q | ~rx_s;
          end
        end
      end
      ST_DONE: begin
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;
      end
      default: begin
      end
    endcase

    // Bit counter restarts on every state entry (shared by DATA and STOP).
    if (zera) begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      dados_q     <= '0;
      erro_par_q  <= 1'b0;
      erro_stop_q <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
      dados_q     <= dados_d;
      erro_par_q  <= erro_par_d;
      erro_stop_q <= erro_stop_d;
    end
  end

  assign dados         = dados_q;
  assign erro_paridade = erro_par_q;
  assign erro_stop     = erro_stop_q;

endmodule

// File: tb/tb_rx_serial_param.sv
// -----------------------------------------------------------------------------
// tb_rx_serial_param
// Two receivers share clock and reset:
//   u_a : CLK_DIV=8, 7 data bits, even parity, 1 stop bit (7E1)
//   u_b : CLK_DIV=8, 8 data bits, no parity, 2 stop bits (8N2)
// Frames are driven bit by bit on the falling edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_rx_serial_param;

  localparam int CLK_DIV = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic [6:0] dados_a;
  logic       pronto_a, ep_a, es_a, busy_a;
  logic [3:0] st_a;

  logic [7:0] dados_b;
  logic       pronto_b, ep_b, es_b, busy_b;
  logic [3:0] st_b;

  rx_serial_param #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (7),
    .PARITY    (1),
    .STOP_BITS (1)
  ) u_a (
    .clock         (clk),
    .reset         (rst),
    .RX            (rx_a),
    .dados         (dados_a),
    .pronto        (pronto_a),
    .erro_paridade (ep_a),
    .erro_stop     (es_a),
    .ocupado       (busy_a),
    .db_estado     (st_a)
  );

  rx_serial_param #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (8),
    .PARITY    (0),
    .STOP_BITS (2)
  ) u_b (
    .clock         (clk),
    .reset         (rst),
    .RX            (rx_b),
    .dados         (dados_b),
    .pronto        (pronto_b),
    .erro_paridade (ep_b),
    .erro_stop     (es_b),
    .ocupado       (busy_b),
    .db_estado     (st_b)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int         cnt_a = 0;
  int         wide_a = 0;
  logic       prev_pr_a = 1'b0;
  logic [6:0] got_d_a = '0;
  logic       got_ep_a = 1'b0;
  logic       got_es_a = 1'b0;

  always @(negedge clk) begin
    if (pronto_a) begin
      cnt_a++;
      got_d_a  = dados_a;
      got_ep_a = ep_a;
      got_es_a = es_a;
      if (prev_pr_a) begin
        wide_a++;
      end
    end
    prev_pr_a = pronto_a;
  end

  logic [7:0] exp_q[$];
  int         cnt_b = 0;

  always @(negedge clk) begin
    if (pronto_b) begin
      cnt_b++;
      if (exp_q.size() == 0) begin
        check("b_unexpected_pronto", 32'(cnt_b), 32'd0);
      end else begin
        check("b_dados", 32'(dados_b), 32'(exp_q.pop_front()));
      end
      check("b_erro_stop", 32'(es_b), 32'd0);
      check("b_erro_paridade", 32'(ep_b), 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // 7E1 frame on rx_a; busy_ok reports whether ocupado was high at the middle
  // of every bit between the start bit and the stop bit.
  task automatic send_a(input logic [6:0] d, input logic par, input logic stp,
                        output logic busy_ok);
    logic [9:0] fr;
    fr = {stp, par, d, 1'b0};
    busy_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_a = fr[i];
      repeat (CLK_DIV / 2) @(negedge clk);
      if (i >= 1 && i <= 8 && busy_a !== 1'b1) begin
        busy_ok = 1'b0;
      end
      repeat (CLK_DIV - CLK_DIV / 2) @(negedge clk);
    end
    rx_a = 1'b1;
  endtask

  // 8N2 frame on rx_b
  task automatic send_b(input logic [7:0] d);
    logic [10:0] fr;
    fr = {2'b11, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_b = fr[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx_b = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic       ok;
    logic [9:0] fr;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Reset state
    check("rst_dados_a", 32'(dados_a), 32'h0);
    check("rst_pronto_a", 32'(pronto_a), 32'h0);
    check("rst_ep_a", 32'(ep_a), 32'h0);
    check("rst_es_a", 32'(es_a), 32'h0);
    check("rst_ocupado_a", 32'(busy_a), 32'h0);
    check("rst_estado_a", 32'(st_a), 32'h0);
    check("rst_dados_b", 32'(dados_b), 32'h0);

    // 0x41, correct even parity (two ones -> parity bit 0)
    send_a(7'h41, 1'b0, 1'b1, ok);
    idle(8);
    check("f1_pronto_count", 32'(cnt_a), 32'd1);
    check("f1_dados", 32'(got_d_a), 32'h41);
    check("f1_ep", 32'(got_ep_a), 32'h0);
    check("f1_es", 32'(got_es_a), 32'h0);
    check("f1_ocupado_frame", 32'(ok), 32'h1);
    check("f1_pronto_one_cycle", 32'(wide_a), 32'd0);
    check("f1_idle_after", 32'(st_a), 32'h0);

    // 0x41 with wrong parity bit
    send_a(7'h41, 1'b1, 1'b1, ok);
    idle(8);
    check("f2_pronto_count", 32'(cnt_a), 32'd2);
    check("f2_dados", 32'(got_d_a), 32'h41);
    check("f2_ep", 32'(got_ep_a), 32'h1);
    check("f2_es", 32'(got_es_a), 32'h0);

    // Stop bit low -> framing error, pronto still pulses
    send_a(7'h41, 1'b0, 1'b0, ok);
    idle(16);
    check("f3_pronto_count", 32'(cnt_a), 32'd3);
    check("f3_es", 32'(got_es_a), 32'h1);
    check("f3_ep", 32'(got_ep_a), 32'h0);
    check("f3_not_locked", 32'(st_a), 32'h0);

    // Valid 0x55 (four ones -> parity bit 0) clears the framing flag
    send_a(7'h55, 1'b0, 1'b1, ok);
    idle(8);
    check("f4_pronto_count", 32'(cnt_a), 32'd4);
    check("f4_dados", 32'(got_d_a), 32'h55);
    check("f4_es", 32'(got_es_a), 32'h0);
    check("f4_ep", 32'(got_ep_a), 32'h0);

    // 3-cycle low glitch: shorter than half a bit, must be rejected
    rx_a = 1'b0;
    idle(3);
    rx_a = 1'b1;
    idle(16);
    check("glitch_pronto_count", 32'(cnt_a), 32'd4);
    check("glitch_dados", 32'(dados_a), 32'h55);
    check("glitch_estado", 32'(st_a), 32'h0);

    // Reset in the middle of the 4th data bit of 0x7F
    fr = {1'b1, 1'b1, 7'h7F, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx_a = fr[i];
      idle(CLK_DIV);
    end
    rx_a = fr[4];
    idle(4);
    check("mid_frame_busy", 32'(busy_a), 32'h1);
    rst  = 1'b1;
    rx_a = 1'b1;
    idle(1);
    check("midrst_dados", 32'(dados_a), 32'h0);
    check("midrst_pronto", 32'(pronto_a), 32'h0);
    check("midrst_ep", 32'(ep_a), 32'h0);
    check("midrst_es", 32'(es_a), 32'h0);
    check("midrst_ocupado", 32'(busy_a), 32'h0);
    check("midrst_estado", 32'(st_a), 32'h0);
    rst = 1'b0;
    idle(16);
    check("midrst_no_pronto", 32'(cnt_a), 32'd4);

    // 0x12 after the aborted frame (two ones -> parity bit 0)
    send_a(7'h12, 1'b0, 1'b1, ok);
    idle(8);
    check("f5_pronto_count", 32'(cnt_a), 32'd5);
    check("f5_dados", 32'(got_d_a), 32'h12);
    check("f5_ep", 32'(got_ep_a), 32'h0);
    check("f5_es", 32'(got_es_a), 32'h0);
    check("f5_pronto_one_cycle", 32'(wide_a), 32'd0);

    // 8N2 back-to-back frames, no idle gap
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_b(8'hA5);
    send_b(8'h3C);
    idle(16);
    check("b_pronto_count", 32'(cnt_b), 32'd2);
    check("b_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b_dados_final", 32'(dados_b), 32'h3C);
    check("b_estado_final", 32'(st_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
